// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the shift-add multiplier sequencer
package mult_pkg;

    localparam int MULT_N = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } mult_state_t;

    typedef struct packed {
        logic clr_a;
        logic load_b;
        logic add;
        logic sub;
        logic shift;
    } mult_ctrl_t;

endpackage

// File: rtl/mult_sequencer.sv
// mult_sequencer: valid/ready control sequencer for the shift-add signed multiplier datapath
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          M,
    output logic          clr_a,
    output logic          load_b,
    output logic          add,
    output logic          sub,
    output logic          shift,
    output logic          busy,
    output logic [CW-1:0] step,
    output logic          done_valid,
    input  logic          done_ready
);

    mult_state_t   state, state_nxt;
    logic [CW-1:0] step_q, step_nxt;
    mult_ctrl_t    ctrl;
    logic          last;

    assign last = step_q == CW'(N - 1);

    // State and step registers; reset abandons any operation in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            step_q <= '0;
        end else begin
            state  <= state_nxt;
            step_q <= step_nxt;
        end
    end

    // Next-state, step advance and strobe decode; only add/sub look at M, and only in ADD
    always_comb begin
        state_nxt = state;
        step_nxt  = step_q;
        ctrl      = '0;
        case (state)
            IDLE:  state_nxt = start_valid ? LOAD : IDLE;
            LOAD: begin
                ctrl.clr_a  = 1'b1;
                ctrl.load_b = 1'b1;
                step_nxt    = '0;
                state_nxt   = ADD;
            end
            ADD: begin
                ctrl.add  = M && !last;
                ctrl.sub  = M && last;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ctrl.shift = 1'b1;
                state_nxt  = last ? DONE : ADD;
                step_nxt   = last ? '0 : step_q + 1'b1;
            end
            DONE:    state_nxt = done_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign start_ready = state == IDLE;
    assign clr_a       = ctrl.clr_a;
    assign load_b      = ctrl.load_b;
    assign add         = ctrl.add;
    assign sub         = ctrl.sub;
    assign shift       = ctrl.shift;
    assign busy        = state == LOAD || state == ADD || state == SHIFT;
    assign step        = step_q;
    assign done_valid  = state == DONE;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: table-driven, per-cycle scoreboard bench for mult_sequencer
module tb_mult_sequencer;

    localparam int N  = 8;
    localparam int CW = 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start_valid = 1'b0;
    logic          start_ready;
    logic          M = 1'b0;
    logic          clr_a, load_b, add, sub, shift, busy, done_valid;
    logic [CW-1:0] step;
    logic          done_ready = 1'b0;

    typedef struct packed {
        logic          start_ready;
        logic          clr_a;
        logic          load_b;
        logic          add;
        logic          sub;
        logic          shift;
        logic          busy;
        logic [CW-1:0] step;
        logic          done_valid;
    } outv_t;

    typedef struct {
        logic [7:0] b;
        int         hold;
        bit         keep;
        int         abort;
        int         n_add;
        int         n_sub;
    } vec_t;

    outv_t act;
    outv_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    assign act = {start_ready, clr_a, load_b, add, sub, shift, busy, step, done_valid};

    always #5 Clk = ~Clk;

    mult_sequencer #(.N(N), .CW(CW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .M          (M),
        .clr_a      (clr_a),
        .load_b     (load_b),
        .add        (add),
        .sub        (sub),
        .shift      (shift),
        .busy       (busy),
        .step       (step),
        .done_valid (done_valid),
        .done_ready (done_ready)
    );

    function automatic outv_t idle_vec();
        outv_t e = '0;
        e.start_ready = 1'b1;
        return e;
    endfunction

    // Expected outputs j cycles after the accepting edge, from the fixed schedule
    function automatic outv_t exp_vec(input logic [7:0] b, input int j);
        outv_t e = '0;
        int k;
        if (j == 1) begin
            e.clr_a  = 1'b1;
            e.load_b = 1'b1;
            e.busy   = 1'b1;
        end else if (j <= 2 * N + 1) begin
            k      = (j - 2) / 2;
            e.busy = 1'b1;
            e.step = CW'(k);
            if ((j - 2) % 2 == 0) begin
                e.add = b[k] && k < N - 1;
                e.sub = b[k] && k == N - 1;
            end else begin
                e.shift = 1'b1;
            end
        end else begin
            e.done_valid = 1'b1;
        end
        return e;
    endfunction

    task automatic check(input string name, input outv_t a, input outv_t e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (rdy clr ld add sub sh busy step dv)", name, a, e);
        end
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, a, e);
        end
    endtask

    // Entered #1 after a posedge in an IDLE cycle; leaves in the same position
    task automatic run(input vec_t v);
        outv_t e;
        int    na = 0;
        int    ns = 0;
        int    last = 2 * N + 2 + v.hold;
        start_valid = 1'b1;
        M           = 1'($urandom);
        done_ready  = 1'($urandom);
        @(negedge Clk);
        check($sformatf("b%02h_idle", v.b), act, idle_vec());
        @(posedge Clk);
        for (int j = 1; j <= last; j++) q.push_back(exp_vec(v.b, j));
        for (int j = 1; j <= last; j++) begin
            #1;
            start_valid = v.keep ? 1'b1 : 1'($urandom);
            M           = (j <= 2 * N + 1 && j >= 2 && j % 2 == 0) ? v.b[(j - 2) / 2] : 1'($urandom);
            done_ready  = j < 2 * N + 2 ? 1'($urandom) : (j == last);
            if (j == v.abort) Reset = 1'b1;
            @(negedge Clk);
            e = q.pop_front();
            check($sformatf("b%02h_c%0d", v.b, j), act, e);
            na += int'(act.add);
            ns += int'(act.sub);
            @(posedge Clk);
            if (j == v.abort) break;
        end
        #1;
        Reset       = 1'b0;
        start_valid = v.keep;
        done_ready  = 1'b0;
        q.delete();
        check_int($sformatf("b%02h_adds", v.b), na, v.n_add);
        check_int($sformatf("b%02h_subs", v.b), ns, v.n_sub);
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{b: 8'h85, hold: 5, keep: 1'b1, abort: 0,  n_add: 2, n_sub: 1};
        tbl[1] = '{b: 8'h00, hold: 0, keep: 1'b0, abort: 0,  n_add: 0, n_sub: 0};
        tbl[2] = '{b: 8'hFF, hold: 2, keep: 1'b0, abort: 11, n_add: 5, n_sub: 0};
        tbl[3] = '{b: 8'h85, hold: 0, keep: 1'b0, abort: 0,  n_add: 2, n_sub: 1};
        tbl[4] = '{b: 8'h80, hold: 1, keep: 1'b0, abort: 0,  n_add: 0, n_sub: 1};
        tbl[5] = '{b: 8'h01, hold: 3, keep: 1'b1, abort: 0,  n_add: 1, n_sub: 0};
        tbl[6] = '{b: 8'hA5, hold: 0, keep: 1'b0, abort: 0,  n_add: 3, n_sub: 1};
        Reset       = 1'b1;
        start_valid = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_state", act, idle_vec());
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 7; i++) run(tbl[i]);
        start_valid = 1'b0;
        @(negedge Clk);
        check("final_idle", act, idle_vec());
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("final_idle_hold", act, idle_vec());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Handshake-driven sequencer for the 8-bit shift-add signed multiplier datapath (A/B shift registers, 9-bit adder/subtractor, X sign flop).
- Accepts one multiply request, then issues clear/load, add/sub and shift strobes for a fixed N-step schedule.
- Holds a done indication until the consumer acknowledges it.
- Replaces button-level run control with valid/ready, so a host FSM or bus interface can drive the multiplier back-to-back.

Parameters:
- N, 8, operand width; number of add/shift steps.
- CW, $clog2(N), step counter width.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- start_valid  in  1  requester has operands on the datapath S bus.
- start_ready  out  1  sequencer can accept a request; high only in IDLE.
- M  in  1  current multiplier LSB from the datapath (B[0]).
- clr_a  out  1  clear A register and X flop.
- load_b  out  1  load B register from S.
- add  out  1  load A/X with A+S.
- sub  out  1  load A/X with A-S.
- shift  out  1  arithmetic right shift of X:A:B.
- busy  out  1  high from LOAD through the final SHIFT.
- step  out  CW  index of the current step (0..N-1); 0 outside ADD/SHIFT.
- done_valid  out  1  product valid on A:B.
- done_ready  in  1  consumer accepts the product.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - next state is IDLE; step=0.
  - all strobes, busy and done_valid are 0; start_ready is 1.
  - Reset mid-operation abandons the operation; the datapath is not cleared by this block.
- States: IDLE, LOAD, ADD, SHIFT, DONE. Outputs are Moore-style, decoded from registered state, except add/sub, which also depend on M.
- IDLE:
  - start_ready=1.
  - start_valid&start_ready at the rising edge -> LOAD.
- LOAD (1 cycle): clr_a=1, load_b=1 -> ADD; step=0.
- ADD (1 cycle):
  - If M=1 and step<N-1, add=1.
  - If M=1 and step==N-1, sub=1 (two's-complement sign correction).
  - If M=0, no strobe; the state is still occupied, giving fixed timing.
  - Next state: SHIFT.
- SHIFT (1 cycle): shift=1.
  - If step==N-1 -> DONE.
  - Else step<=step+1 -> ADD.
  - The step counter never wraps past N-1.
- DONE:
  - done_valid=1, held stable until done_ready.
  - done_valid&done_ready -> IDLE.
  - done_ready while not in DONE is ignored.
- Latency with accept at edge 0:
  - LOAD occupies cycle 1.
  - ADD/SHIFT occupy cycles 2..2N+1.
  - done_valid first seen in cycle 2N+2 (cycle 18 for N=8).
- Throughput: one multiply per 2N+3 cycles minimum.
  - A new start is accepted one cycle after the DONE handshake, never in the same cycle.
- Mutual exclusion: at most one of {clr_a|load_b, add, sub, shift} is asserted in any cycle.
- start_valid while busy or in DONE is not accepted. The requester must hold start_valid and S until start_ready.
- M is sampled only in ADD; M changes elsewhere are ignored.

Decomposition:
- Shared package mult_pkg:
  - typedef enum logic [2:0] mult_state_t {IDLE, LOAD, ADD, SHIFT, DONE}.
  - localparam MULT_N=8.
  - Strobe-bundle struct mult_ctrl_t {clr_a, load_b, add, sub, shift}.
- Single module; the step counter stays inline. No sub-module is warranted.

Test Plan:
- Reset held 3 cycles, then start_valid=1 -> start_ready=1 in cycle 0, accepted, clr_a=load_b=1 in cycle 1 only, busy=1.
- M stream for B=0x85, bit order LSB-first 1,0,1,0,0,0,0,1 -> add at steps 0 and 2, no strobe at steps 1 and 3..6, sub at step 7 only, 8 shift pulses, done_valid in cycle 18.
- M=0 on every step (B=0x00) -> zero add/sub pulses, 8 shifts, identical 18-cycle latency.
- DONE with done_ready low for 5 cycles -> done_valid held, all strobes 0. Then done_ready=1 -> IDLE next cycle; start_valid held high is accepted the cycle after.
- Reset asserted during step 4 SHIFT -> next cycle IDLE, step=0, all strobes 0, start_ready=1; a fresh request then completes normally in 18 cycles.
- start_valid pulsed during busy and DONE -> not accepted: no extra LOAD, and the step sequence is unchanged.
